// File: rtl/uart_rx_fifo_if.sv
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : CPU-side bus of the serial receive FIFO (pop, error clear, status)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_rx_fifo_if #(
  parameter int AW = 2
);
  logic          rd;
  logic          clr_err;
  logic [7:0]    dout;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          frame_err;
  logic          overrun;
  logic          intr;

  modport master (
    output rd, clr_err,
    input  dout, empty, full, count, frame_err, overrun, intr
  );

  modport slave (
    input  rd, clr_err,
    output dout, empty, full, count, frame_err, overrun, intr
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : 8N1 serial receiver feeding a fall-through byte FIFO with IRQ
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4,
  parameter int AW           = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         uart_rx,
  uart_rx_fifo_if.slave     bus
);

  localparam int             CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  c_half_m1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  c_last      = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic          r_sync1, r_sync2;
  logic          w_rx_s;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_stop_ok, w_stop_bad;
  logic          r_push;
  logic          r_frame_err, r_overrun;
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic [7:0]    r_mem [DEPTH];
  logic          w_empty, w_full, w_pop, w_push, w_drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_push  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_push  <= w_stop_ok;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == c_half_m1) begin
          w_cnt_nxt = '0;
          w_idx_nxt = '0;
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == c_last) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx_s, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == c_last) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_stop_ok   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Stay here until the line recovers so a held-low line flags only once.
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The shift register is stable for the cycle after the stop sample, so it
  // serves directly as the write data.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = bus.rd && !w_empty;
  assign w_push  = r_push && (!w_full || w_pop);
  assign w_drop  = r_push && w_full && !bus.rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_stop_bad)       r_frame_err <= 1'b1;
      else if (bus.clr_err) r_frame_err <= 1'b0;
      if (w_drop)           r_overrun   <= 1'b1;
      else if (bus.clr_err) r_overrun   <= 1'b0;
    end
  end

  assign bus.dout      = r_mem[r_rd_ptr[AW-1:0]];
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.count     = r_wr_ptr - r_rd_ptr;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;
  assign bus.intr      = !w_empty || r_frame_err || r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic clk;
  logic reset;
  logic uart_rx;
  int   total;
  int   bad;

  uart_rx_fifo_if #(.AW(2)) bus ();

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (4),
    .AW           (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .uart_rx (uart_rx),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All stimulus changes and samples happen on falling edges.
  task automatic send_bit(input logic b);
    uart_rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic pop();
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  task automatic clear_flags();
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    total++; if ({bus.frame_err, bus.overrun, bus.intr} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {bus.frame_err, bus.overrun, bus.intr}); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int lat;
    lat = 0;
    fork
      send_byte(8'h55, 1'b1);
      begin
        for (int i = 1; i <= 400; i++) begin
          @(negedge clk);
          if (bus.empty === 1'b0) begin lat = i; break; end
        end
      end
    join
    total++; if (lat < 150 || lat > 162) begin bad++; $display("FAIL latency got=%0d cycles exp=150..162", lat); end
    total++; if (bus.dout !== 8'h55) begin bad++; $display("FAIL single_dout got=%h exp=55", bus.dout); end
    total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", bus.count); end
    total++; if (bus.intr !== 1'b1) begin bad++; $display("FAIL single_intr got=%b exp=1", bus.intr); end
    pop();
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL single_pop_empty got=%b exp=1", bus.empty); end
    total++; if (bus.intr !== 1'b0) begin bad++; $display("FAIL single_pop_intr got=%b exp=0", bus.intr); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_glitch();
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL glitch_empty got=%b exp=1", bus.empty); end
    total++; if ({bus.frame_err, bus.overrun} !== 2'b00) begin bad++; $display("FAIL glitch_flags got=%b exp=00", {bus.frame_err, bus.overrun}); end
  endtask

  task automatic test_frame_err();
    send_byte(8'h3C, 1'b0);
    repeat (3) send_bit(1'b0);
    total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL ferr_set got=%b exp=1", bus.frame_err); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL ferr_empty got=%b exp=1", bus.empty); end
    total++; if (bus.intr !== 1'b1) begin bad++; $display("FAIL ferr_intr got=%b exp=1", bus.intr); end
    uart_rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL ferr_no_refire_count got=%0d exp=0", bus.count); end
    clear_flags();
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL ferr_clear got=%b exp=0", bus.frame_err); end
    total++; if (bus.intr !== 1'b0) begin bad++; $display("FAIL ferr_clear_intr got=%b exp=0", bus.intr); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp_b [4];
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 1'b1);
      repeat (2) @(negedge clk);
    end
    total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL ovr_full got=%b exp=1", bus.full); end
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", bus.overrun); end
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL ovr_count got=%0d exp=4", bus.count); end
    clear_flags();
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", bus.overrun); end
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL ovr_clear_keeps_fifo got=%0d exp=4", bus.count); end
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.dout !== exp_b[i]) begin bad++; $display("FAIL ovr_pop%0d got=%h exp=%h", i, bus.dout, exp_b[i]); end
      pop();
    end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL ovr_drained got=%b exp=1", bus.empty); end
    pop();
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL ovr_pop_empty_count got=%0d exp=0", bus.count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [4];
    exp_b = '{8'h20, 8'h30, 8'h40, 8'hA7};
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h30, 1'b1);
    send_byte(8'h40, 1'b1);
    repeat (2) @(negedge clk);
    total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL b2b_prefull got=%b exp=1", bus.full); end
    fork
      send_byte(8'hA7, 1'b1);
      begin
        repeat (155) @(negedge clk);
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", bus.count); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b exp=0", bus.overrun); end
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.dout !== exp_b[i]) begin bad++; $display("FAIL b2b_pop%0d got=%h exp=%h", i, bus.dout, exp_b[i]); end
      pop();
    end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL b2b_drained got=%b exp=1", bus.empty); end
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h5A, 1'b1);
    repeat (2) @(negedge clk);
    send_bit(1'b0);
    repeat (4) send_bit(1'b1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL mid_reset_empty got=%b exp=1", bus.empty); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL mid_reset_count got=%0d exp=0", bus.count); end
    total++; if ({bus.full, bus.frame_err, bus.overrun, bus.intr} !== 4'b0000) begin bad++; $display("FAIL mid_reset_flags got=%b exp=0000", {bus.full, bus.frame_err, bus.overrun, bus.intr}); end
    reset = 1'b1;
    repeat (4) send_bit(1'b1);
    repeat (CPB) @(negedge clk);
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL mid_tail_empty got=%b exp=1", bus.empty); end
    send_byte(8'h81, 1'b1);
    repeat (2) @(negedge clk);
    total++; if (bus.dout !== 8'h81) begin bad++; $display("FAIL mid_next_dout got=%h exp=81", bus.dout); end
    total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL mid_next_count got=%0d exp=1", bus.count); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL mid_next_ferr got=%b exp=0", bus.frame_err); end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b0;
    uart_rx     = 1'b1;
    bus.rd      = 1'b0;
    bus.clr_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
